stopwatch_lap_ctrl: RTL and testbench

Parametrised stopwatch control and timebase block. It takes raw push-button levels, synchronises, debounces and edge-detects them, and runs a start/pause/clear state machine. It generates the tick prescaler and elapsed-time counter, and stores lap times in a circular lap buffer with newest-first readback. It sits between the board buttons and the display formatter, and replaces the separate controller-plus-counter arrangement.

---
 rtl/stopwatch_lap_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_stopwatch_lap_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch controller: button conditioning, IDLE/RUN/PAUSE control, tick timebase,
// saturating elapsed-time counter and a circular lap buffer read back newest-first.
module stopwatch_lap_ctrl #(
  parameter int CLK_DIV    = 100000,
  parameter int TIME_WIDTH = 24,
  parameter int LAP_DEPTH  = 4,
  parameter int DEB_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           btn_start_stop,
  input  logic                           btn_lap,
  input  logic                           btn_clear,
  input  logic [$clog2(LAP_DEPTH)-1:0]   lap_rd_idx,
  output logic [TIME_WIDTH-1:0]          time_out,
  output logic                           running,
  output logic                           overflow,
  output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
  output logic [TIME_WIDTH-1:0]          lap_rd_data,
  output logic                           lap_pulse
);

  localparam int IDX_W = $clog2(LAP_DEPTH);
  localparam int CNT_W = $clog2(LAP_DEPTH + 1);
  localparam int PRE_W = $clog2(CLK_DIV);
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  localparam int B_START = 0;
  localparam int B_LAP   = 1;
  localparam int B_CLEAR = 2;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  logic [2:0]            rawBtn;
  logic [2:0]            sync1_q, sync2_q;
  logic [2:0]            deb_q, deb_d, debPrev_q;
  logic [2:0][DEB_W-1:0] debCnt_q, debCnt_d;
  logic [2:0]            rise;
  logic                  clrEv, ssEv, lapEv;

  state_t                state_q, state_d;
  logic                  lapStore;
  logic                  tickEn;

  logic [PRE_W-1:0]      presc_q, presc_d;
  logic [TIME_WIDTH-1:0] time_q, time_d;
  logic                  ovf_q, ovf_d;

  logic [IDX_W-1:0]      wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0]      lapCnt_q, lapCnt_d;
  logic                  pulse_q;
  logic [TIME_WIDTH-1:0] mem_q [LAP_DEPTH];
  logic [TIME_WIDTH-1:0] rdData_q, rdData_d;
  logic [IDX_W-1:0]      rdAddr;
  int                    rdAddrInt;

  assign rawBtn = {btn_clear, btn_lap, btn_start_stop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      debPrev_q <= '0;
      debCnt_q  <= '0;
    end else begin
      sync1_q   <= rawBtn;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      debPrev_q <= deb_q;
      debCnt_q  <= debCnt_d;
    end
  end

  // Any agreement between input and debounced level restarts the count.
  always_comb begin
    deb_d    = deb_q;
    debCnt_d = '0;
    for (int b = 0; b < 3; b++) begin
      if (sync2_q[b] != deb_q[b]) begin
        if (debCnt_q[b] == DEB_W'(DEB_CYCLES - 1)) begin
          deb_d[b] = sync2_q[b];
        end else begin
          debCnt_d[b] = debCnt_q[b] + 1'b1;
        end
      end
    end
  end

  assign rise  = deb_q & ~debPrev_q;
  assign clrEv = rise[B_CLEAR];
  assign ssEv  = rise[B_START] & ~rise[B_CLEAR];
  assign lapEv = rise[B_LAP] & ~rise[B_START] & ~rise[B_CLEAR];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lapStore = 1'b0;
    if (clrEv) begin
      state_d = IDLE;
    end else if (ssEv) begin
      state_d = (state_q == RUN) ? PAUSE : RUN;
    end else if (lapEv && (state_q == RUN)) begin
      lapStore = 1'b1;
    end
  end

  // Prescaler only advances in RUN so a resume continues the partial tick.
  always_comb begin
    presc_d = presc_q;
    time_d  = time_q;
    ovf_d   = ovf_q;
    tickEn  = 1'b0;
    if (state_q == RUN) begin
      if (presc_q == PRE_W'(CLK_DIV - 1)) begin
        presc_d = '0;
        tickEn  = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
    if (tickEn) begin
      if (&time_q) begin
        ovf_d = 1'b1;
      end else begin
        time_d = time_q + 1'b1;
      end
    end
    if (clrEv) begin
      presc_d = '0;
      time_d  = '0;
      ovf_d   = 1'b0;
    end
  end

  always_comb begin
    wrPtr_d  = wrPtr_q;
    lapCnt_d = lapCnt_q;
    if (lapStore) begin
      wrPtr_d = (wrPtr_q == IDX_W'(LAP_DEPTH - 1)) ? '0 : wrPtr_q + 1'b1;
      if (lapCnt_q != CNT_W'(LAP_DEPTH)) begin
        lapCnt_d = lapCnt_q + 1'b1;
      end
    end
    if (clrEv) begin
      wrPtr_d  = '0;
      lapCnt_d = '0;
    end
  end

  // Newest-first address; indices past the stored count read as zero.
  always_comb begin
    rdAddrInt = int'(wrPtr_q) - 1 - int'(lap_rd_idx);
    if (rdAddrInt < 0) begin
      rdAddrInt = rdAddrInt + LAP_DEPTH;
    end
    if (rdAddrInt < 0) begin
      rdAddrInt = rdAddrInt + LAP_DEPTH;
    end
    rdAddr   = IDX_W'(rdAddrInt);
    rdData_d = '0;
    if ((int'(lap_rd_idx) < int'(lapCnt_q)) && !clrEv) begin
      rdData_d = mem_q[rdAddr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= '0;
      time_q   <= '0;
      ovf_q    <= 1'b0;
      wrPtr_q  <= '0;
      lapCnt_q <= '0;
      pulse_q  <= 1'b0;
      rdData_q <= '0;
    end else begin
      presc_q  <= presc_d;
      time_q   <= time_d;
      ovf_q    <= ovf_d;
      wrPtr_q  <= wrPtr_d;
      lapCnt_q <= lapCnt_d;
      pulse_q  <= lapStore;
      rdData_q <= rdData_d;
    end
  end

  always_ff @(posedge clk) begin
    if (lapStore) begin
      mem_q[wrPtr_q] <= time_q;
    end
  end

  assign time_out    = time_q;
  assign running     = (state_q == RUN);
  assign overflow    = ovf_q;
  assign lap_count   = lapCnt_q;
  assign lap_rd_data = rdData_q;
  assign lap_pulse   = pulse_q;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed bench for stopwatch_lap_ctrl: expectations are queued as each step is
// driven and drained against the outputs one cycle-edge plus 1 time unit later.
module tb_stopwatch_lap_ctrl;

  localparam int CLK_DIV    = 4;
  localparam int TIME_WIDTH = 4;
  localparam int LAP_DEPTH  = 2;
  localparam int DEB_CYCLES = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btnStart = 1'b0;
  logic       btnLap = 1'b0;
  logic       btnClear = 1'b0;
  logic [0:0] rdIdx = 1'b0;

  logic [TIME_WIDTH-1:0] timeOut;
  logic                  running;
  logic                  overflow;
  logic [1:0]            lapCount;
  logic [TIME_WIDTH-1:0] lapRdData;
  logic                  lapPulse;

  typedef enum {SIG_RUN, SIG_TIME, SIG_OVF, SIG_LAPS, SIG_RD, SIG_PULSE} sig_t;
  typedef struct {
    sig_t  sig;
    int    value;
    string tag;
  } expect_t;

  expect_t pending[$];
  int total = 0;
  int bad = 0;

  stopwatch_lap_ctrl #(
    .CLK_DIV(CLK_DIV),
    .TIME_WIDTH(TIME_WIDTH),
    .LAP_DEPTH(LAP_DEPTH),
    .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_start_stop(btnStart),
    .btn_lap(btnLap),
    .btn_clear(btnClear),
    .lap_rd_idx(rdIdx),
    .time_out(timeOut),
    .running(running),
    .overflow(overflow),
    .lap_count(lapCount),
    .lap_rd_data(lapRdData),
    .lap_pulse(lapPulse)
  );

  always #5 clk = ~clk;

  task automatic stepEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic l, input logic c);
    btnStart = s;
    btnLap   = l;
    btnClear = c;
  endtask

  task automatic expectOut(input sig_t sig, input int value, input string tag);
    expect_t e;
    e.sig   = sig;
    e.value = value;
    e.tag   = tag;
    pending.push_back(e);
  endtask

  function automatic int observe(input sig_t sig);
    case (sig)
      SIG_RUN:   return int'(running);
      SIG_TIME:  return int'(timeOut);
      SIG_OVF:   return int'(overflow);
      SIG_LAPS:  return int'(lapCount);
      SIG_RD:    return int'(lapRdData);
      SIG_PULSE: return int'(lapPulse);
      default:   return -1;
    endcase
  endfunction

  task automatic checkOutput();
    expect_t e;
    int obs;
    while (pending.size() > 0) begin
      e   = pending.pop_front();
      obs = observe(e.sig);
      total++;
      assert (obs === e.value) else begin
        bad++;
        $error("[TB] FAIL %s got=%0d want=%0d", e.tag, obs, e.value);
      end
    end
  endtask

  task automatic expectResetOutputs(input string where);
    expectOut(SIG_RUN,   0, {where, "_run"});
    expectOut(SIG_TIME,  0, {where, "_time"});
    expectOut(SIG_OVF,   0, {where, "_ovf"});
    expectOut(SIG_LAPS,  0, {where, "_laps"});
    expectOut(SIG_RD,    0, {where, "_rd"});
    expectOut(SIG_PULSE, 0, {where, "_pulse"});
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0);
    rdIdx = 1'b0;
    rst_n = 1'b0;
    stepEdges(2);
    rst_n = 1'b1;
    stepEdges(1);
  endtask

  initial begin
    // Reset values and start latency / first ticks.
    doReset();
    expectResetOutputs("rst");
    checkOutput();
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepEdges(4);
    expectOut(SIG_RUN, 0, "start_early");
    checkOutput();
    stepEdges(1);
    expectOut(SIG_RUN, 1, "start_lat5");
    expectOut(SIG_TIME, 0, "start_t0");
    checkOutput();
    stepEdges(3);
    expectOut(SIG_TIME, 0, "tick_early");
    checkOutput();
    stepEdges(1);
    expectOut(SIG_TIME, 1, "tick_first");
    checkOutput();
    stepEdges(8);
    expectOut(SIG_TIME, 3, "t12_time3");
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Glitch rejection and single event on a long hold.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepEdges(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepEdges(10);
    expectOut(SIG_RUN, 0, "glitch_idle");
    expectOut(SIG_TIME, 0, "glitch_time");
    checkOutput();
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepEdges(40);
    expectOut(SIG_RUN, 1, "hold_single");
    expectOut(SIG_TIME, 8, "hold_time");
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Pause with a partial tick, hold, resume.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepEdges(5);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepEdges(4);
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepEdges(5);
    expectOut(SIG_RUN, 0, "pause_state");
    expectOut(SIG_TIME, 2, "pause_time");
    checkOutput();
    stepEdges(30);
    expectOut(SIG_RUN, 0, "pause_hold");
    expectOut(SIG_TIME, 2, "pause_frozen");
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepEdges(5);
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepEdges(5);
    expectOut(SIG_RUN, 1, "resume_state");
    expectOut(SIG_TIME, 2, "resume_time");
    checkOutput();
    stepEdges(2);
    expectOut(SIG_TIME, 2, "resume_partial");
    checkOutput();
    stepEdges(1);
    expectOut(SIG_TIME, 3, "resume_tick3");
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Lap buffer wrap with laps at 2, 5 and 7.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepEdges(5);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepEdges(5);
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepEdges(5);
    expectOut(SIG_PULSE, 1, "lap1_pulse");
    expectOut(SIG_LAPS, 1, "lap1_count");
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepEdges(1);
    expectOut(SIG_PULSE, 0, "lap1_pulse_off");
    expectOut(SIG_RD, 2, "lap1_rd0");
    checkOutput();
    stepEdges(5);
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepEdges(5);
    expectOut(SIG_PULSE, 1, "lap2_pulse");
    expectOut(SIG_LAPS, 2, "lap2_count");
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepEdges(1);
    expectOut(SIG_PULSE, 0, "lap2_pulse_off");
    expectOut(SIG_RD, 5, "lap2_rd0");
    checkOutput();
    stepEdges(2);
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepEdges(5);
    expectOut(SIG_PULSE, 1, "lap3_pulse");
    expectOut(SIG_LAPS, 2, "lap3_count_sat");
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepEdges(1);
    expectOut(SIG_PULSE, 0, "lap3_pulse_off");
    expectOut(SIG_RD, 7, "wrap_rd0");
    checkOutput();
    rdIdx = 1'b1;
    stepEdges(1);
    expectOut(SIG_RD, 5, "wrap_rd1");
    expectOut(SIG_TIME, 7, "wrap_time");
    expectOut(SIG_RUN, 1, "wrap_run");
    checkOutput();
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepEdges(5);
    expectOut(SIG_RUN, 0, "lap_pause_state");
    checkOutput();
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepEdges(5);
    expectOut(SIG_LAPS, 2, "pause_lap_count");
    expectOut(SIG_PULSE, 0, "pause_lap_pulse");
    expectOut(SIG_RD, 5, "pause_lap_rd1");
    checkOutput();
    rdIdx = 1'b0;
    stepEdges(1);
    expectOut(SIG_RD, 7, "pause_lap_rd0");
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Overflow saturation, then clear+start together.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepEdges(5);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepEdges(5);
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepEdges(5);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepEdges(53);
    expectOut(SIG_TIME, 15, "ovf_pre_time");
    expectOut(SIG_OVF, 0, "ovf_pre_flag");
    expectOut(SIG_LAPS, 1, "ovf_pre_laps");
    expectOut(SIG_RD, 2, "ovf_pre_rd0");
    checkOutput();
    stepEdges(1);
    expectOut(SIG_TIME, 15, "ovf_sat_time");
    expectOut(SIG_OVF, 1, "ovf_set");
    expectOut(SIG_RUN, 1, "ovf_run");
    checkOutput();
    stepEdges(4);
    expectOut(SIG_TIME, 15, "ovf_hold_time");
    expectOut(SIG_OVF, 1, "ovf_sticky");
    checkOutput();
    applyStimulus(1'b1, 1'b0, 1'b1);
    stepEdges(4);
    expectOut(SIG_RUN, 1, "clr_early");
    checkOutput();
    stepEdges(1);
    expectResetOutputs("clr");
    checkOutput();
    stepEdges(20);
    expectOut(SIG_RUN, 0, "clr_held_idle");
    expectOut(SIG_TIME, 0, "clr_held_time");
    expectOut(SIG_RD, 0, "clr_held_rd0");
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-RUN, then a fresh debounced press.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepEdges(5);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepEdges(5);
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepEdges(5);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepEdges(14);
    expectOut(SIG_TIME, 6, "arst_pre_time");
    expectOut(SIG_LAPS, 1, "arst_pre_laps");
    checkOutput();
    rst_n = 1'b0;
    #1;
    expectResetOutputs("arst");
    checkOutput();
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepEdges(2);
    rst_n = 1'b1;
    stepEdges(4);
    expectOut(SIG_RUN, 0, "post_rst_early");
    checkOutput();
    stepEdges(1);
    expectOut(SIG_RUN, 1, "post_rst_start");
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
